// File: rtl/ascon_pack.sv
// Shared Ascon types: block width, word/tag types and the host sequencer state enum.
package ascon_pack;

  localparam int BLOCK_WIDTH = 64;

  typedef logic [BLOCK_WIDTH-1:0]   u64_t;
  typedef logic [2*BLOCK_WIDTH-1:0] u128_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    TAG_WAIT,
    TAG_HI,
    TAG_LO
  } ascon_host_state_t;

endpackage

// File: rtl/ascon_host_seq.sv
// Host-side sequencer for one Ascon encryption job: feeds AD/PT blocks into the
// wrapper FIFOs, drains CT into a single-entry output register, then emits the tag.
module ascon_host_seq
  import ascon_pack::*;
#(
  parameter int DATA_AW   = 7,
  parameter int FifoDepth = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go_i,
  input  logic [DATA_AW-1:0] ad_size_i,
  input  logic [DATA_AW-1:0] pt_size_i,
  output logic               busy_o,
  output logic               done_o,
  input  logic               in_valid_i,
  input  u64_t               in_data_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  output u64_t               out_data_o,
  output logic               out_last_o,
  input  logic               out_ready_i,
  output logic               start_o,
  input  logic               ready_i,
  output logic               ad_push_o,
  output u64_t               ad_o,
  input  logic               ad_full_i,
  output logic               pt_push_o,
  output u64_t               pt_o,
  input  logic               pt_full_i,
  output logic               ct_pop_o,
  input  u64_t               ct_i,
  input  logic               ct_empty_i,
  input  logic               tag_valid_i,
  input  u128_t              tag_i
);

  localparam int CW = DATA_AW - 2;
  localparam int TW = DATA_AW - 1;

  if (FifoDepth < 1) begin : g_depth_check
    $error("ascon_host_seq: FifoDepth must be at least 1");
  end

  // Byte count rounded up to whole 64-bit blocks.
  function automatic logic [CW-1:0] blocks(input logic [DATA_AW-1:0] sz);
    logic [DATA_AW:0] t;
    t = {1'b0, sz} + (DATA_AW+1)'(7);
    return t[DATA_AW:3];
  endfunction

  ascon_host_state_t state, state_nx;
  logic [CW-1:0] nad, npt, ct_cnt;
  logic [TW-1:0] in_cnt, total;
  u128_t         tag_q;
  logic          in_left, in_ad, target_full, in_fire, out_free;
  logic          stream_done, tag_load_hi, tag_load_lo, tag_lo_ack;

  assign total       = TW'(nad) + TW'(npt);
  assign in_left     = in_cnt < total;
  assign in_ad       = in_cnt < TW'(nad);
  assign target_full = in_ad ? ad_full_i : pt_full_i;
  assign in_ready_o  = (state == STREAM) && in_left && !target_full;
  assign in_fire     = in_valid_i & in_ready_o;
  assign ad_push_o   = in_fire & in_ad;
  assign pt_push_o   = in_fire & ~in_ad;
  assign ad_o        = in_data_i;
  assign pt_o        = in_data_i;

  assign out_free    = !out_valid_o || out_ready_i;
  assign ct_pop_o    = (state == STREAM) && !ct_empty_i && (ct_cnt < npt) && out_free;
  assign stream_done = !in_left && (ct_cnt == npt);

  // The low tag beat is the only one loaded with last set, so out_last_o marks it.
  assign tag_load_hi = (state == TAG_HI) && out_free;
  assign tag_lo_ack  = (state == TAG_LO) && out_valid_o && out_last_o && out_ready_i;
  assign tag_load_lo = (state == TAG_LO) && !(out_valid_o && out_last_o) && out_free;

  assign done_o  = tag_lo_ack;
  assign start_o = (state == START) && ready_i;
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (go_i)        state_nx = START;
      START:    if (ready_i)     state_nx = STREAM;
      STREAM:   if (stream_done) state_nx = TAG_WAIT;
      TAG_WAIT: if (tag_valid_i) state_nx = TAG_HI;
      TAG_HI:   if (out_free)    state_nx = TAG_LO;
      TAG_LO:   if (tag_lo_ack)  state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nad    <= '0;
      npt    <= '0;
      in_cnt <= '0;
      ct_cnt <= '0;
    end else if (state == IDLE) begin
      if (go_i) begin
        nad    <= blocks(ad_size_i);
        npt    <= blocks(pt_size_i);
        in_cnt <= '0;
        ct_cnt <= '0;
      end
    end else begin
      if (in_fire)  in_cnt <= in_cnt + TW'(1);
      if (ct_pop_o) ct_cnt <= ct_cnt + CW'(1);
    end
  end

  // Single-entry output register shared by CT words and both tag halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      out_data_o  <= '0;
    end else if (ct_pop_o) begin
      out_valid_o <= 1'b1;
      out_last_o  <= 1'b0;
      out_data_o  <= ct_i;
    end else if (tag_load_hi) begin
      out_valid_o <= 1'b1;
      out_last_o  <= 1'b0;
      out_data_o  <= tag_q[127:64];
    end else if (tag_load_lo) begin
      out_valid_o <= 1'b1;
      out_last_o  <= 1'b1;
      out_data_o  <= tag_q[63:0];
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == TAG_WAIT && tag_valid_i) tag_q <= tag_i;
  end

endmodule

// File: tb/tb_ascon_host_seq.sv
// Scoreboard bench for ascon_host_seq with a small behavioural wrapper model
// (FWFT CT FIFO computed as PT xor a fixed mask, level tag_valid).
module tb_ascon_host_seq;
  import ascon_pack::*;

  localparam int   DATA_AW = 7;
  localparam u64_t MASK    = 64'h5A5A_0F0F_3C3C_9696;

  typedef struct {
    u64_t data;
    logic last;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               go_i = 1'b0;
  logic [DATA_AW-1:0] ad_size_i = '0;
  logic [DATA_AW-1:0] pt_size_i = '0;
  logic               busy_o, done_o;
  logic               in_valid_i = 1'b0;
  u64_t               in_data_i = '0;
  logic               in_ready_o;
  logic               out_valid_o, out_last_o;
  u64_t               out_data_o;
  logic               out_ready_i = 1'b1;
  logic               start_o;
  logic               ready_i = 1'b1;
  logic               ad_push_o, pt_push_o, ct_pop_o;
  u64_t               ad_o, pt_o;
  logic               ad_full_i = 1'b0;
  logic               pt_full_i = 1'b0;
  u64_t               ct_i = '0;
  logic               ct_empty_i = 1'b1;
  logic               tag_valid_i = 1'b0;
  u128_t              tag_i = '0;

  int    n_vec = 0;
  int    n_fail = 0;
  beat_t exp_q[$];
  u64_t  ad_got[$];
  u64_t  pt_got[$];
  u64_t  ct_q[$];
  int    ct_pops = 0;
  int    done_cnt = 0;
  int    start_cnt = 0;
  int    exp_nad = 0;
  int    exp_npt = 0;
  bit    job_active = 1'b0;
  int    full_cycles = 0;
  bit    tog_en = 1'b0;
  int    tog_idx = 0;
  bit    stall_prev = 1'b0;
  u64_t  data_prev = '0;

  ascon_host_seq #(.DATA_AW(DATA_AW), .FifoDepth(4)) dut (
    .clk(clk), .rst_n(rst_n), .go_i(go_i),
    .ad_size_i(ad_size_i), .pt_size_i(pt_size_i),
    .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i),
    .start_o(start_o), .ready_i(ready_i),
    .ad_push_o(ad_push_o), .ad_o(ad_o), .ad_full_i(ad_full_i),
    .pt_push_o(pt_push_o), .pt_o(pt_o), .pt_full_i(pt_full_i),
    .ct_pop_o(ct_pop_o), .ct_i(ct_i), .ct_empty_i(ct_empty_i),
    .tag_valid_i(tag_valid_i), .tag_i(tag_i)
  );

  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic u64_t ad_word(input int i);
    return 64'hAD00_1111_0000_0000 + u64_t'(i);
  endfunction

  function automatic u64_t pt_word(input int i);
    return 64'hC0DE_2222_0000_0000 + u64_t'(i * 3 + 1);
  endfunction

  // Wrapper model: FIFO pushes/pops on the active edge, FWFT CT output, level tag_valid.
  always @(posedge clk) begin
    if (!rst_n) begin
      ct_q.delete();
      job_active = 1'b0;
      ct_empty_i <= 1'b1;
      ct_i       <= '0;
      tag_valid_i <= 1'b0;
    end else begin
      if (start_o) begin
        job_active = 1'b1;
        start_cnt++;
      end
      if (ct_pop_o) begin
        check64("ct_pop_on_empty", 64'(ct_q.size() == 0), 64'd0);
        if (ct_q.size() != 0) begin
          void'(ct_q.pop_front());
          ct_pops++;
        end
      end
      if (pt_push_o) begin
        check64("pt_push_while_full", 64'(pt_full_i), 64'd0);
        pt_got.push_back(pt_o);
        ct_q.push_back(pt_o ^ MASK);
      end
      if (ad_push_o) ad_got.push_back(ad_o);
      if (done_o) job_active = 1'b0;
      ct_empty_i  <= (ct_q.size() == 0);
      ct_i        <= (ct_q.size() != 0) ? ct_q[0] : '0;
      tag_valid_i <= job_active && (ad_got.size() == exp_nad) && (pt_got.size() == exp_npt);
    end
  end

  // Monitor: sample between edges; a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check64("stall_valid_hold", 64'(out_valid_o), 64'd1);
        check64("stall_data_hold", out_data_o, data_prev);
      end
      if (ct_pop_o) check64("pop_while_stalled", 64'(out_valid_o && !out_ready_i), 64'd0);
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h last=%b, expected no beat", out_data_o, out_last_o);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check64("out_data", out_data_o, b.data);
          check64("out_last", 64'(out_last_o), 64'(b.last));
        end
      end
      if (done_o) done_cnt++;
      stall_prev = out_valid_o && !out_ready_i;
      data_prev  = out_data_o;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (full_cycles > 0) begin
        pt_full_i = 1'b1;
        full_cycles--;
      end else begin
        pt_full_i = 1'b0;
      end
      if (tog_en) begin
        out_ready_i = (tog_idx % 4 == 0) || (tog_idx % 4 == 3);
        tog_idx++;
      end else begin
        out_ready_i = 1'b1;
      end
    end
  end

  task automatic send_word(input u64_t data, input bit pulse_go);
    int c;
    in_valid_i = 1'b1;
    in_data_i  = data;
    go_i       = pulse_go;
    c = 0;
    while (!in_ready_o && c < 100) begin
      @(negedge clk);
      go_i = 1'b0;
      c++;
    end
    if (c >= 100) begin
      n_vec++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", c);
    end
    @(negedge clk);
    go_i = 1'b0;
  endtask

  task automatic begin_job(input int ad_sz, input int pt_sz, input u128_t tag);
    ad_got.delete();
    pt_got.delete();
    ct_pops   = 0;
    done_cnt  = 0;
    start_cnt = 0;
    exp_nad   = (ad_sz + 7) / 8;
    exp_npt   = (pt_sz + 7) / 8;
    tag_i     = tag;
    ad_size_i = DATA_AW'(ad_sz);
    pt_size_i = DATA_AW'(pt_sz);
    @(negedge clk);
    go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
  endtask

  task automatic run_job(input int ad_sz, input int pt_sz, input u128_t tag, input bit go_mid);
    int nad, npt, c;
    nad = (ad_sz + 7) / 8;
    npt = (pt_sz + 7) / 8;
    for (int i = 0; i < npt; i++) exp_q.push_back('{pt_word(i) ^ MASK, 1'b0});
    exp_q.push_back('{tag[127:64], 1'b0});
    exp_q.push_back('{tag[63:0], 1'b1});
    begin_job(ad_sz, pt_sz, tag);
    check64("busy_after_go", 64'(busy_o), 64'd1);
    for (int i = 0; i < nad + npt; i++)
      send_word((i < nad) ? ad_word(i) : pt_word(i - nad), go_mid && (i == 1));
    in_valid_i = 1'b0;
    c = 0;
    while (done_cnt == 0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    check64("done_pulses", 64'(done_cnt), 64'd1);
    check64("start_pulses", 64'(start_cnt), 64'd1);
    check64("ad_push_count", 64'(ad_got.size()), 64'(nad));
    check64("pt_push_count", 64'(pt_got.size()), 64'(npt));
    check64("ct_pop_count", 64'(ct_pops), 64'(npt));
    check64("beats_left", 64'(exp_q.size()), 64'd0);
    check64("busy_idle", 64'(busy_o), 64'd0);
    for (int i = 0; i < nad; i++)
      if (i < ad_got.size()) check64("ad_data", ad_got[i], ad_word(i));
    for (int i = 0; i < npt; i++)
      if (i < pt_got.size()) check64("pt_data", pt_got[i], pt_word(i));
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    check64("rst_busy", 64'(busy_o), 64'd0);
    check64("rst_done", 64'(done_o), 64'd0);
    check64("rst_start", 64'(start_o), 64'd0);
    check64("rst_in_ready", 64'(in_ready_o), 64'd0);
    check64("rst_out_valid", 64'(out_valid_o), 64'd0);
    check64("rst_out_last", 64'(out_last_o), 64'd0);
    check64("rst_ad_push", 64'(ad_push_o), 64'd0);
    check64("rst_pt_push", 64'(pt_push_o), 64'd0);
    check64("rst_ct_pop", 64'(ct_pop_o), 64'd0);
    check64("rst_out_data", out_data_o, 64'd0);
  endtask

  initial begin
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job(16, 16, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1);
    run_job(9, 0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
    run_job(0, 0, 128'hA0A0_B1B1_C2C2_D3D3_E4E4_F5F5_0606_1717, 1'b0);
    full_cycles = 10;
    run_job(0, 40, 128'hDEAD_BEEF_0000_1111_CAFE_F00D_2222_3333, 1'b0);
    tog_en  = 1'b1;
    tog_idx = 0;
    run_job(8, 32, 128'h9999_8888_7777_6666_5555_4444_3333_2222, 1'b0);
    tog_en = 1'b0;

    // Abandon a job mid-stream; only AD words go in so no CT beat is in flight.
    begin_job(16, 16, 128'h5555_5555_5555_5555_AAAA_AAAA_AAAA_AAAA);
    send_word(ad_word(0), 1'b0);
    send_word(ad_word(1), 1'b0);
    check64("busy_in_stream", 64'(busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    in_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check64("abandon_pt_pushes", 64'(pt_got.size()), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job(8, 8, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ascon_host_seq.md
ASCON_HOST_SEQ -- requirements
Module: ascon_host_seq

Interface
REQ-001 SHALL have parameters: DATA_AW, default 7, width of byte-size fields; FifoDepth, default 4, ascon_wrapper FIFO depth, informational only.
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  single clock;
  rst_n  in  1  asynchronous active-low reset;
  go_i  in  1  start one encryption job;
  ad_size_i / pt_size_i  in  DATA_AW  AD/PT length in bytes;
  busy_o  out  1  job in progress;
  done_o  out  1  one-cycle pulse when the last tag beat is accepted;
  in_valid_i  in  1, in_data_i  in  64, in_ready_o  out  1  source stream, AD blocks then PT blocks;
  out_valid_o  out  1, out_data_o  out  64, out_last_o  out  1, out_ready_i  in  1  sink stream, CT blocks then tag;
  start_o  out  1, ready_i  in  1  wrapper start handshake;
  ad_push_o  out  1, ad_o  out  64, ad_full_i  in  1  wrapper AD FIFO;
  pt_push_o  out  1, pt_o  out  64, pt_full_i  in  1  wrapper PT FIFO;
  ct_pop_o  out  1, ct_i  in  64, ct_empty_i  in  1  wrapper CT FIFO (first-word-fall-through);
  tag_valid_i  in  1, tag_i  in  128  wrapper tag.

Function
REQ-003 Block counts SHALL be nad = ceil(ad_size_i/8) and npt = ceil(pt_size_i/8), each DATA_AW-2 bits wide, latched on go_i; a size of 0 SHALL give 0 blocks.
REQ-004 The FSM SHALL have states IDLE, START, STREAM, TAG_WAIT, TAG_HI, TAG_LO.
REQ-005 IDLE: go_i=1 SHALL latch sizes and go to START. In any other state go_i SHALL be ignored.
REQ-006 START: start_o SHALL be asserted for exactly one cycle, in the first cycle with ready_i=1, then the FSM SHALL go to STREAM.
REQ-007 STREAM forwarding: source words 0..nad-1 SHALL go to the AD FIFO and words nad..nad+npt-1 to the PT FIFO.
REQ-008 in_ready_o SHALL be 1 only in STREAM while words remain and the target FIFO full flag is 0.
REQ-009 ad_push_o/pt_push_o SHALL equal in_valid_i & in_ready_o for the selected FIFO, combinationally, with data passed through unchanged.
REQ-010 CT draining SHALL run concurrently with REQ-007.
REQ-011 ct_pop_o SHALL be 1 when ct_empty_i=0, CT words remain (of npt), and the output register is empty or out_ready_i=1.
REQ-012 A popped word SHALL appear on out_data_o the next cycle (latency 1) with out_valid_o=1 and out_last_o=0.
REQ-013 STREAM SHALL go to TAG_WAIT when all nad+npt input words are accepted and npt CT words are popped.
REQ-014 TAG_WAIT: the cycle with tag_valid_i=1 SHALL capture tag_i and go to TAG_HI.
REQ-015 TAG_HI SHALL present tag[127:64] once the output register frees; TAG_LO SHALL present tag[63:0] with out_last_o=1.
REQ-016 Acceptance of the TAG_LO beat (out_valid_o & out_ready_i) SHALL pulse done_o and return the FSM to IDLE.
REQ-017 out_valid_o, once set, SHALL hold with stable data until out_ready_i=1 (no drop under back-pressure).
REQ-018 With nad=npt=0, STREAM SHALL exit after one cycle and the sink SHALL receive only the two tag beats.
REQ-019 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE, clear all counters and the output register, and drive 0 on start_o, busy_o, done_o, in_ready_o, out_valid_o, out_last_o, ad_push_o, pt_push_o and ct_pop_o; out_data_o SHALL reset to 0.
REQ-021 Reset mid-job SHALL abandon the job with no further pushes or pops; flushing the wrapper FIFOs SHALL remain the wrapper's responsibility.

Structure
REQ-022 BLOCK_WIDTH, u64_t and u128_t SHALL come from ascon_pack; the FSM state enum SHALL be added to ascon_pack as ascon_host_state_t.
REQ-023 No sub-module is needed; the single-entry output register SHALL be local logic.

Verification
REQ-024 ad=16, pt=16, sink always ready, wrapper model: 2 AD pushes then 2 PT pushes; 2 CT beats then tag_hi, tag_lo (last=1); done_o pulses once.
REQ-025 ad=9, pt=0: 2 AD pushes, 0 PT pushes, no CT pops; the output is only the 2 tag beats.
REQ-026 ad=0, pt=40 with pt_full_i held high for 10 cycles: no push while full; 5 PT pushes total; 5 CT beats in order.
REQ-027 out_ready_i toggling 1-0-0-1: out_data_o is stable while stalled; no CT word is lost or duplicated; ct_pop_o is never 1 while the register is full and out_ready_i=0.
REQ-028 go_i during STREAM is ignored; rst_n asserted in STREAM sets busy_o=0 immediately; the next job with ad=8, pt=8 completes normally.
